dcache_gnt_monitor: RTL and testbench

Parametrised, synthesizable grant monitor for the std cache subsystem. It generalises the fixed 5/3-bit grant probe bundles to NR_PORTS arbiter channels. Per port it counts grants, tracks wait latency, flags starvation, and checks arbiter legality (one-hot grant, no grant without request), capturing the first fault with a timestamp. It is instantiated beside any dcache arbiter (rd, miss, bypass, wr) and is read by the tb scoreboard or a debug CSR.

---
 rtl/dcache_gnt_monitor.sv | 140 ++++++++++++++
 tb/tb_dcache_gnt_monitor.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/dcache_gnt_monitor.sv
// Grant monitor for a dcache arbiter: per-port grant counts, wait latency and
// starvation, plus first-fault capture for illegal grant patterns.
module dcache_gnt_monitor #(
  parameter int unsigned NR_PORTS     = 5,
  parameter int unsigned CNT_WIDTH    = 16,
  parameter int unsigned STARVE_LIMIT = 64
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            en_i,
  input  logic                            clear_i,
  input  logic [NR_PORTS-1:0]             req_i,
  input  logic [NR_PORTS-1:0]             gnt_i,
  output logic [NR_PORTS*CNT_WIDTH-1:0]   gnt_cnt_o,
  output logic [NR_PORTS*CNT_WIDTH-1:0]   max_wait_o,
  output logic [NR_PORTS-1:0]             starve_o,
  output logic                            fault_o,
  output logic [1:0]                      fault_type_o,
  output logic [$clog2(NR_PORTS)-1:0]     fault_port_o,
  output logic [CNT_WIDTH-1:0]            fault_time_o
);

  localparam int unsigned PW = $clog2(NR_PORTS);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] LIMIT   = CNT_WIDTH'(STARVE_LIMIT);

  typedef enum logic {MON, FAULT} state_e;

  state_e                 state_q, state_d;
  logic [1:0]             ftype_q, ftype_d;
  logic [PW-1:0]          fport_q, fport_d;
  logic [CNT_WIDTH-1:0]   ftime_q, ftime_d;
  logic [CNT_WIDTH-1:0]   cyc_q;
  logic [CNT_WIDTH-1:0]   gnt_cnt_q  [NR_PORTS];
  logic [CNT_WIDTH-1:0]   max_wait_q [NR_PORTS];
  logic [CNT_WIDTH-1:0]   wait_q     [NR_PORTS];
  logic [CNT_WIDTH-1:0]   wait_d     [NR_PORTS];
  logic [NR_PORTS-1:0]    starve_q;

  logic [NR_PORTS-1:0]    bad_gnt;
  logic                   multi_gnt;
  logic [PW-1:0]          gnt_low, bad_low;

  // Clearing the lowest set bit leaves something only if two or more grants are set.
  always_comb begin
    bad_gnt   = gnt_i & ~req_i;
    multi_gnt = |(gnt_i & (gnt_i - NR_PORTS'(1)));
    gnt_low   = '0;
    bad_low   = '0;
    for (int i = NR_PORTS - 1; i >= 0; i--) begin
      if (gnt_i[i])   gnt_low = PW'(i);
      if (bad_gnt[i]) bad_low = PW'(i);
    end
  end

  // Fault FSM next state and capture.
  always_comb begin
    state_d = state_q;
    ftype_d = ftype_q;
    fport_d = fport_q;
    ftime_d = ftime_q;
    if (clear_i) begin
      state_d = MON;
      ftype_d = '0;
      fport_d = '0;
      ftime_d = '0;
    end else if (en_i && (state_q == MON) && (multi_gnt || (|bad_gnt))) begin
      state_d = FAULT;
      ftype_d = multi_gnt ? 2'b01 : 2'b10;
      fport_d = multi_gnt ? gnt_low : bad_low;
      ftime_d = cyc_q;
    end
  end

  // Saturating per-port wait counters.
  always_comb begin
    for (int p = 0; p < NR_PORTS; p++) begin
      wait_d[p] = wait_q[p];
      if (en_i) begin
        if (req_i[p] && !gnt_i[p])
          wait_d[p] = (wait_q[p] == CNT_MAX) ? wait_q[p] : wait_q[p] + CNT_WIDTH'(1);
        else
          wait_d[p] = '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= MON;
      ftype_q  <= '0;
      fport_q  <= '0;
      ftime_q  <= '0;
      cyc_q    <= '0;
      starve_q <= '0;
      for (int p = 0; p < NR_PORTS; p++) begin
        gnt_cnt_q[p]  <= '0;
        max_wait_q[p] <= '0;
        wait_q[p]     <= '0;
      end
    end else begin
      state_q <= state_d;
      ftype_q <= ftype_d;
      fport_q <= fport_d;
      ftime_q <= ftime_d;
      if (clear_i) begin
        cyc_q    <= '0;
        starve_q <= '0;
        for (int p = 0; p < NR_PORTS; p++) begin
          gnt_cnt_q[p]  <= '0;
          max_wait_q[p] <= '0;
          wait_q[p]     <= '0;
        end
      end else if (en_i) begin
        cyc_q <= cyc_q + CNT_WIDTH'(1);
        for (int p = 0; p < NR_PORTS; p++) begin
          wait_q[p] <= wait_d[p];
          if (req_i[p] && gnt_i[p] && (gnt_cnt_q[p] != CNT_MAX))
            gnt_cnt_q[p] <= gnt_cnt_q[p] + CNT_WIDTH'(1);
          if (wait_d[p] > max_wait_q[p])
            max_wait_q[p] <= wait_d[p];
          if (wait_d[p] == LIMIT)
            starve_q[p] <= 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < NR_PORTS; g++) begin : g_pack
    assign gnt_cnt_o[g*CNT_WIDTH +: CNT_WIDTH]  = gnt_cnt_q[g];
    assign max_wait_o[g*CNT_WIDTH +: CNT_WIDTH] = max_wait_q[g];
  end

  assign starve_o     = starve_q;
  assign fault_o      = (state_q == FAULT);
  assign fault_type_o = ftype_q;
  assign fault_port_o = fport_q;
  assign fault_time_o = ftime_q;

endmodule

// File: tb/tb_dcache_gnt_monitor.sv
// Scoreboard bench for dcache_gnt_monitor: directed scenarios then random
// traffic, each cycle's expected outputs produced by a count-based model.
module tb_dcache_gnt_monitor;

  localparam int NP = 5;
  localparam int CW = 8;
  localparam int SL = 12;
  localparam int PW = $clog2(NP);
  localparam int CMAX = (1 << CW) - 1;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic              en_i = 1'b0;
  logic              clear_i = 1'b0;
  logic [NP-1:0]     req_i = '0;
  logic [NP-1:0]     gnt_i = '0;
  logic [NP*CW-1:0]  gnt_cnt_o, max_wait_o;
  logic [NP-1:0]     starve_o;
  logic              fault_o;
  logic [1:0]        fault_type_o;
  logic [PW-1:0]     fault_port_o;
  logic [CW-1:0]     fault_time_o;

  dcache_gnt_monitor #(.NR_PORTS(NP), .CNT_WIDTH(CW), .STARVE_LIMIT(SL)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .clear_i(clear_i),
    .req_i(req_i), .gnt_i(gnt_i),
    .gnt_cnt_o(gnt_cnt_o), .max_wait_o(max_wait_o), .starve_o(starve_o),
    .fault_o(fault_o), .fault_type_o(fault_type_o),
    .fault_port_o(fault_port_o), .fault_time_o(fault_time_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [NP*CW-1:0] gc;
    logic [NP*CW-1:0] mw;
    logic [NP-1:0]    st;
    logic             f;
    logic [1:0]       ft;
    logic [PW-1:0]    fp;
    logic [CW-1:0]    tm;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference state as plain counts
  int m_cyc, m_f, m_ft, m_fp, m_tm;
  int m_gc[NP], m_w[NP], m_mw[NP], m_st[NP];

  function automatic int min_i(int a, int b); return (a < b) ? a : b; endfunction

  task automatic model_zero();
    m_cyc = 0; m_f = 0; m_ft = 0; m_fp = 0; m_tm = 0;
    for (int p = 0; p < NP; p++) begin
      m_gc[p] = 0; m_w[p] = 0; m_mw[p] = 0; m_st[p] = 0;
    end
  endtask

  function automatic exp_t snap();
    exp_t e;
    for (int p = 0; p < NP; p++) begin
      e.gc[p*CW +: CW] = CW'(m_gc[p]);
      e.mw[p*CW +: CW] = CW'(m_mw[p]);
      e.st[p]          = (m_st[p] != 0);
    end
    e.f  = (m_f != 0);
    e.ft = 2'(m_ft);
    e.fp = PW'(m_fp);
    e.tm = CW'(m_tm);
    return e;
  endfunction

  task automatic step(input logic r, input logic e, input logic c,
                      input logic [NP-1:0] rq, input logic [NP-1:0] g);
    int n, first, found;
    @(negedge clk_i);
    rst_ni = r; en_i = e; clear_i = c; req_i = rq; gnt_i = g;
    if (!r || c) begin
      model_zero();
    end else if (e) begin
      if (m_f == 0) begin
        n = 0; first = -1;
        for (int p = 0; p < NP; p++)
          if (g[p]) begin n++; if (first < 0) first = p; end
        if (n > 1) begin
          m_f = 1; m_ft = 1; m_fp = first; m_tm = m_cyc;
        end else begin
          found = 0;
          for (int p = 0; p < NP; p++)
            if (!found && g[p] && !rq[p]) begin
              found = 1; m_f = 1; m_ft = 2; m_fp = p; m_tm = m_cyc;
            end
        end
      end
      m_cyc = (m_cyc + 1) % (CMAX + 1);
      for (int p = 0; p < NP; p++) begin
        if (rq[p] && g[p]) m_gc[p] = min_i(m_gc[p] + 1, CMAX);
        m_w[p] = (rq[p] && !g[p]) ? min_i(m_w[p] + 1, CMAX) : 0;
        if (m_w[p] > m_mw[p]) m_mw[p] = m_w[p];
        if (m_w[p] == SL) m_st[p] = 1;
      end
    end
    sb.push_back(snap());
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at vector %0d: got %h expected %h", name, vectors, act, exp);
    end
  endtask

  // Monitor: every clock the DUT presents a new registered state
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_i);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        vectors++;
        chk("gnt_cnt",    64'(gnt_cnt_o),    64'(e.gc));
        chk("max_wait",   64'(max_wait_o),   64'(e.mw));
        chk("starve",     64'(starve_o),     64'(e.st));
        chk("fault",      64'(fault_o),      64'(e.f));
        chk("fault_type", 64'(fault_type_o), 64'(e.ft));
        chk("fault_port", 64'(fault_port_o), 64'(e.fp));
        chk("fault_time", 64'(fault_time_o), 64'(e.tm));
      end
    end
  end

  initial begin
    logic [NP-1:0] rq, g;
    int pick, mode;
    model_zero();
    repeat (3) step(1'b0, 1'b1, 1'b0, '0, '0);
    // idle 10 cycles
    repeat (10) step(1'b1, 1'b1, 1'b0, '0, '0);
    // port 2 waits 3 then is granted
    repeat (3) step(1'b1, 1'b1, 1'b0, 5'b00100, '0);
    step(1'b1, 1'b1, 1'b0, 5'b00100, 5'b00100);
    // port 0 starves past the limit, stays flagged, then clear
    repeat (SL + 2) step(1'b1, 1'b1, 1'b0, 5'b00001, '0);
    repeat (3) step(1'b1, 1'b1, 1'b0, '0, '0);
    step(1'b1, 1'b1, 1'b1, '0, '0);
    // multi-grant at cycle 20, later grant-without-request must not overwrite
    repeat (20) step(1'b1, 1'b1, 1'b0, '0, '0);
    step(1'b1, 1'b1, 1'b0, 5'b01100, 5'b01100);
    repeat (4) step(1'b1, 1'b1, 1'b0, '0, '0);
    step(1'b1, 1'b1, 1'b0, 5'b00000, 5'b10000);
    step(1'b1, 1'b1, 1'b0, '0, '0);
    // reset, grant without request at cycle 7, then clear together with a grant
    step(1'b0, 1'b1, 1'b0, '0, '0);
    repeat (7) step(1'b1, 1'b1, 1'b0, '0, '0);
    step(1'b1, 1'b1, 1'b0, 5'b00000, 5'b10000);
    step(1'b1, 1'b1, 1'b0, '0, '0);
    step(1'b1, 1'b1, 1'b1, 5'b00010, 5'b00010);
    step(1'b1, 1'b1, 1'b0, '0, '0);
    // enable low holds everything
    repeat (4) step(1'b1, 1'b0, 1'b0, 5'b00011, 5'b10000);
    // saturation: port 1 granted 300 cycles
    step(1'b1, 1'b1, 1'b1, '0, '0);
    repeat (300) step(1'b1, 1'b1, 1'b0, 5'b00010, 5'b00010);
    // random traffic
    for (int i = 0; i < 2500; i++) begin
      rq = NP'($urandom);
      if (i < 1300) rq[3] = 1'b1;
      mode = int'($urandom_range(0, 99));
      pick = int'($urandom_range(0, NP - 1));
      g = '0;
      if (mode < 80) begin
        if (rq[pick]) g[pick] = 1'b1;
      end else if (mode >= 95) begin
        g = NP'($urandom);
      end
      step(($urandom_range(0, 999) >= 3), ($urandom_range(0, 9) != 0),
           ($urandom_range(0, 99) < 2), rq, g);
    end
    // drain the scoreboard with a bounded wait
    for (int k = 0; k < 5 && sb.size() > 0; k++) @(negedge clk_i);
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected vectors never checked, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
